// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard controller for the 5-stage pipeline. Sequences
// load-use stalls, branch flushes and data-memory wait freezes across the
// IF/ID, ID/EX and EX/MEM registers, and selects EX-stage ALU operand
// forwarding from the MEM and WB stages.
// Optional feature: define HAZ_PERF_CNT_EN to add the saturating StallCount
// and FlushCount performance counters.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,   // total flushed cycles per taken branch, 1..3
  parameter int MEM_TIMEOUT  = 15   // busy cycles before MemTimeout sets, 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_RegisterRd,
  input  logic [4:0]  EX_rs,
  input  logic [4:0]  EX_rt,
  input  logic        MEM_RegWrite,
  input  logic [4:0]  MEM_RegisterRd,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_RegisterRd,
  input  logic        BranchTaken,
  input  logic        MemBusy,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        EXMEM_Hold,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        MemTimeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
`endif
);

  typedef enum logic [1:0] {RUN, LDUSE, MEMWAIT, FLUSH} state_t;

  // Flush cycles still owed after the branch cycle itself.
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  // Busy-counter value seen during the MEM_TIMEOUT-th consecutive busy cycle.
  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     state, nextState;
  state_t     savedState, nextSaved;
  state_t     effState;
  logic [1:0] flushCnt, nextFlushCnt;
  logic [3:0] busyCnt;
  logic       timeoutFlag;
  logic       loadUse;

  // MEM forward wins over WB; register 0 never forwards.
  function automatic logic [1:0] fwdSel(
    input logic [4:0] src,
    input logic       memWr,
    input logic [4:0] memRd,
    input logic       wbWr,
    input logic [4:0] wbRd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (memWr && (memRd != 5'd0) && (memRd == src))
      sel = 2'b10;
    else if (wbWr && (wbRd != 5'd0) && (wbRd == src))
      sel = 2'b01;
    return sel;
  endfunction

  assign loadUse = EX_MemRead && (EX_RegisterRd != 5'd0) &&
                   ((EX_RegisterRd == ID_rs) ||
                    (ID_UsesRt && (EX_RegisterRd == ID_rt)));

  // Next-state and pipeline control; MemBusy > BranchTaken > load-use.
  always_comb begin
    // NOTE: every output and next-state value is defaulted first so no path
    // through the case leaves one unassigned and no latch is inferred.
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    EXMEM_Hold   = 1'b0;
    nextState    = state;
    nextSaved    = savedState;
    nextFlushCnt = flushCnt;
    // While waiting on memory, the interrupted state's behaviour resumes
    // in the cycle MemBusy drops.
    effState     = (state == MEMWAIT) ? savedState : state;

    if (MemBusy) begin
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
      EXMEM_Hold = 1'b1;
      nextState  = MEMWAIT;
      if (state != MEMWAIT)
        nextSaved = state;
    end else begin
      case (effState)
        RUN, LDUSE: begin
          if (BranchTaken) begin
            IFID_Flush   = 1'b1;
            IDEX_Bubble  = 1'b1;
            nextFlushCnt = FLUSH_RELOAD;
            nextState    = (FLUSH_RELOAD != 2'd0) ? FLUSH : RUN;
          end else if ((effState == RUN) && loadUse) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            nextState   = LDUSE;
          end else begin
            nextState = RUN;
          end
        end
        FLUSH: begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          if (BranchTaken) begin
            // A new branch restarts the count, this cycle being its first.
            nextFlushCnt = FLUSH_RELOAD;
            nextState    = (FLUSH_RELOAD != 2'd0) ? FLUSH : RUN;
          end else begin
            nextFlushCnt = flushCnt - 2'd1;
            nextState    = (flushCnt <= 2'd1) ? RUN : FLUSH;
          end
        end
        default: nextState = RUN;
      endcase
    end

    MemTimeout = timeoutFlag || (MemBusy && (busyCnt >= TIMEOUT_LAST));

    // Outputs show their reset values for as long as reset is held.
    if (!rst_n) begin
      PCWrite     = 1'b1;
      IFID_Write  = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Bubble = 1'b0;
      EXMEM_Hold  = 1'b0;
      MemTimeout  = 1'b0;
    end
  end

  // Operand forwarding, valid in every state.
  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (rst_n) begin
      ForwardA = fwdSel(EX_rs, MEM_RegWrite, MEM_RegisterRd, WB_RegWrite, WB_RegisterRd);
      ForwardB = fwdSel(EX_rt, MEM_RegWrite, MEM_RegisterRd, WB_RegWrite, WB_RegisterRd);
    end
  end

  // State, resume-state and flush-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and updates together.
    if (!rst_n) begin
      state      <= RUN;
      savedState <= RUN;
      flushCnt   <= '0;
    end else begin
      state      <= nextState;
      savedState <= nextSaved;
      flushCnt   <= nextFlushCnt;
    end
  end

  // Consecutive-busy counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyCnt     <= '0;
      timeoutFlag <= 1'b0;
    end else if (MemBusy) begin
      if (busyCnt != 4'hF)
        busyCnt <= busyCnt + 4'd1;
      if (busyCnt >= TIMEOUT_LAST)
        timeoutFlag <= 1'b1;
    end else begin
      busyCnt <= '0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating counts of stalled-PC cycles and IF/ID flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (!PCWrite && (StallCount != 16'hFFFF))
        StallCount <= StallCount + 16'd1;
      if (IFID_Flush && (FlushCount != 16'hFFFF))
        FlushCount <= FlushCount + 16'd1;
    end
  end
`endif

endmodule
